shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the 32-bit logarithmic shifter path.
//   Accepts one shift request through a start/busy/done handshake.
//   Applies the five power-of-two shift stages (1,2,4,8,16), one stage per clock.
//   Sits beside the ALU/multiplier in the midterm datapath. Trades 5 cycles of
//   latency for a single shared stage mux bank.
// PARAMETERS
//   WIDTH   32  data width; fixed at 32 (shift amount is 5 bits, 5 stages)
//   SLL_OP  6'b000000  Signal code: logical shift left
//   SRL_OP  6'b000010  Signal code: logical shift right
//   SRA_OP  6'b000011  Signal code: arithmetic shift right (macro-gated)
// PORTS
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   request; sampled only in IDLE
//   dataA    in   32  operand to shift; captured on accept
//   dataB    in   32  shift amount; only dataB[4:0] used, captured on accept
//   Signal   in   6   operation code; captured on accept
//   busy     out  1   high in SHIFT and DONE; start ignored while high
//   done     out  1   one-cycle pulse; dataOut/err valid in that cycle
//   err      out  1   valid with done; 1 = unsupported Signal
//   dataOut  out  32  result register; holds value until next accept
// BEHAVIOUR
//   Reset (async): state=IDLE; busy=0, done=0, err=0, dataOut=0, stage=0.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE, start=1 at edge E0: capture acc=dataA, amt=dataB[4:0], op=Signal.
//     Same edge: stage=0, go to SHIFT, busy=1.
//     Unsupported op: acc loaded with 0, err latched 1.
//   SHIFT: at each edge Ek (k=1..5), stage s=k-1.
//     If amt[s]=1: acc shifted by 2^s toward the op direction; else acc unchanged.
//     Fill bits: SLL/SRL fill 0; SRA fills acc[31].
//     Unsupported op: acc stays 0 and the stage counter still runs.
//   At E5: dataOut=acc; go to DONE. done=1 for exactly the cycle after E5.
//   Fixed latency: 5 edges from accept to done, independent of amount.
//     amt=0 still takes 5 cycles; result = dataA.
//   DONE: next edge -> IDLE, busy=0, done=0.
//     start is ignored in DONE; earliest re-accept is the edge after DONE.
//   Throughput: one request per 7 cycles.
//   dataB[31:5] are ignored (dataB=0x25 shifts by 5).
//   Input changes after accept have no effect; operands are captured.
//   start high while busy: dropped, not queued; no error.
//   Reset mid-operation: abort immediately to reset values; no done pulse.
//   err is cleared on each accept and held with dataOut until the next accept.
// CONFIGURATION
//   SHIFT_SEQ_SRA_EN defined: SRA_OP accepted; arithmetic right shift, sign-fill.
//   SHIFT_SEQ_SRA_EN undefined: SRA_OP is unsupported.
//     Result: err=1, dataOut=0, same 5-cycle latency.
// TESTING
//   1. SRL: dataA=0x80000000, dataB=31, Signal=SRL_OP -> done 5 clk after accept, dataOut=0x00000001, err=0.
//   2. SLL: dataA=0x00000001, dataB=0x24 -> dataOut=0x00000010 (upper dataB bits ignored).
//   3. Amount 0: dataA=0xDEADBEEF, dataB=0 -> dataOut=0xDEADBEEF after 5 cycles.
//   4. start pulsed at cycles 2 and 4 after accept -> ignored; exactly one done, busy=1 throughout.
//   5. reset asserted during stage 2 -> busy=0, done=0, dataOut=0 at once; no done pulse afterward.
//   6. Signal=SRA_OP, dataA=0x80000000, dataB=4.
//      With macro: dataOut=0xF8000000, err=0. Without macro: dataOut=0, err=1.
//   7. Signal=6'b100000 (unsupported) -> err=1, dataOut=0, done after 5 cycles.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle 32-bit shift sequencer: one power-of-two stage (1,2,4,8,16) per clock.
// Define SHIFT_SEQ_SRA_EN to accept SRA_OP (arithmetic right shift); otherwise it reports err.
module shift_seq_ctrl #(
    parameter int          WIDTH  = 32,
    parameter logic [5:0]  SLL_OP = 6'b000000,
    parameter logic [5:0]  SRL_OP = 6'b000010,
    parameter logic [5:0]  SRA_OP = 6'b000011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] dataOut
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [4:0]       amt;
    logic [5:0]       op;
    logic [2:0]       stage;
    logic [4:0]       sh;
    logic             op_ok;
    logic             unused_b;

    assign unused_b = ^dataB[WIDTH-1:5];

    always_comb begin
        op_ok = (Signal == SLL_OP) || (Signal == SRL_OP);
`ifdef SHIFT_SEQ_SRA_EN
        op_ok = op_ok || (Signal == SRA_OP);
`endif
    end

    // Single shared stage: an unsupported op holds acc at zero, so every arm leaves it zero.
    always_comb begin
        sh       = 5'd1 << stage;
        acc_next = acc;
        if (amt[stage]) begin
            case (op)
                SLL_OP:  acc_next = acc << sh;
                SRL_OP:  acc_next = acc >> sh;
                SRA_OP:  acc_next = $signed(acc) >>> sh;
                default: acc_next = acc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            amt     <= '0;
            op      <= '0;
            stage   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= op_ok ? dataA : '0;
                        amt   <= dataB[4:0];
                        op    <= Signal;
                        err   <= ~op_ok;
                        stage <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    if (stage == 3'd4) begin
                        dataOut <= acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        stage <= stage + 3'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stage <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: hand-computed results, latency, busy/done handshake and reset abort.
module tb_shift_seq_ctrl;

    localparam logic [5:0] SLL = 6'b000000;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] BAD = 6'b100000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic [5:0]  Signal = '0;
    logic        busy, done, err;
    logic [31:0] dataOut;

    int errors = 0;
    int checks = 0;

    shift_seq_ctrl #(.WIDTH(32), .SLL_OP(SLL), .SRL_OP(SRL), .SRA_OP(SRA)) dut (
        .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
        .Signal(Signal), .busy(busy), .done(done), .err(err), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Accept one request, scramble inputs afterwards, then check latency, result and return to idle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] sig, input logic [31:0] exp_d, input logic exp_e);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; dataA = a; dataB = b; Signal = sig;
        @(posedge clk); #1;
        start = 1'b0; dataA = ~a; dataB = b + 32'd3; Signal = 6'h3f;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd5);
        check({tag, " dataOut"}, dataOut, exp_d);
        check({tag, " err"}, 32'(err), 32'(exp_e));
        check({tag, " busy in done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({tag, " done cleared"}, 32'(done), 32'd0);
        check({tag, " busy cleared"}, 32'(busy), 32'd0);
        check({tag, " dataOut held"}, dataOut, exp_d);
    endtask

    initial begin
        int dcount;

        #2;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset dataOut", dataOut, 32'd0);
        @(negedge clk); reset = 1'b0;

        run_op("srl31", 32'h8000_0000, 32'd31, SRL, 32'h0000_0001, 1'b0);
        run_op("bad op", 32'h1234_5678, 32'd3, BAD, 32'h0000_0000, 1'b1);
        run_op("sll hi bits", 32'h0000_0001, 32'h0000_0024, SLL, 32'h0000_0010, 1'b0);
        run_op("amt0", 32'hDEAD_BEEF, 32'd0, SRL, 32'hDEAD_BEEF, 1'b0);
        run_op("sll13", 32'h0000_F00F, 32'h0000_000D, SLL, 32'h1E01_E000, 1'b0);
        run_op("srl28", 32'hF000_0000, 32'hFFFF_FFFC, SRL, 32'h0000_000F, 1'b0);
`ifdef SHIFT_SEQ_SRA_EN
        run_op("sra4", 32'h8000_0000, 32'd4, SRA, 32'hF800_0000, 1'b0);
        run_op("sra pos", 32'h4000_0000, 32'd30, SRA, 32'h0000_0001, 1'b0);
`else
        run_op("sra off", 32'h8000_0000, 32'd4, SRA, 32'h0000_0000, 1'b1);
`endif

        // Start pulses while busy (SHIFT and DONE) must be dropped.
        @(negedge clk);
        start = 1'b1; dataA = 32'h0000_0003; dataB = 32'd2; Signal = SLL;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        for (int c = 1; c <= 8; c++) begin
            start = (c == 2 || c == 4 || c == 6);
            dataA = 32'hFFFF_FFFF; dataB = 32'd1; Signal = SRL;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dcount++;
            if (c <= 5) check($sformatf("busy held c%0d", c), 32'(busy), 32'd1);
        end
        check("ignored starts done count", 32'(dcount), 32'd1);
        check("ignored starts busy idle", 32'(busy), 32'd0);
        check("ignored starts dataOut", dataOut, 32'h0000_000C);

        // Reset while stage 2 is pending aborts at once with no done pulse.
        @(negedge clk);
        start = 1'b1; dataA = 32'h0000_00FF; dataB = 32'd7; Signal = SLL;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort dataOut", dataOut, 32'd0);
        @(negedge clk); reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);

        run_op("after abort", 32'h0000_0001, 32'd31, SLL, 32'h8000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
